// File: rtl/mem_wb_stage.sv
// MEM stage of the five-stage MIPS pipeline: data-memory req/ack port, upstream stall, MEM/WB register.
// Optional access timeout with sticky memErr is enabled by defining MEM_TIMEOUT_EN.
module mem_wb_stage #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] ALUIn,
  input  logic [31:0] DbIn,
  input  logic [4:0]  AwIn,
  input  logic        RegWrIn,
  input  logic        MemWrIn,
  input  logic        MemToRegIn,
  input  logic [31:0] instrIn,
  output logic [31:0] memAddr,
  output logic [31:0] memWData,
  output logic        memWr,
  output logic        memReq,
  input  logic        memAck,
  input  logic [31:0] memRData,
  output logic        stall,
  output logic [31:0] WbDataOut,
  output logic [4:0]  AwOut,
  output logic        RegWrOut,
  output logic [31:0] instrOut,
  output logic        memErr
);

  typedef enum logic {StIdle, StWait} state_e;

  state_e      state_q, state_d;
  logic        mem_op, req, stall_int, complete, timed_out, timeout_hit;
  logic [31:0] wb_data_q, wb_data_d, instr_q, instr_d;
  logic [4:0]  aw_q, aw_d;
  logic        reg_wr_q, reg_wr_d;

  if (TIMEOUT < 1) begin : g_timeout_chk
    $error("TIMEOUT must be at least 1");
  end

  assign mem_op   = MemWrIn | MemToRegIn;
  assign memAddr  = ALUIn;
  assign memWData = DbIn;
  // Reset forces the port idle even though the inputs may still carry a memory op.
  assign memWr    = MemWrIn & ~reset;
  assign memReq   = req & ~reset;
  assign stall    = stall_int & ~reset;

`ifdef MEM_TIMEOUT_EN
  logic [31:0] cnt_q;
  logic        err_q;

  assign timeout_hit = (state_q == StWait) && (cnt_q == TIMEOUT);
  assign memErr      = err_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= (state_q == StIdle) ? '0 : cnt_q + 32'd1;
      err_q <= err_q | timed_out;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign memErr      = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    req       = 1'b0;
    stall_int = 1'b0;
    complete  = 1'b0;
    timed_out = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!mem_op) begin
          complete = 1'b1;
        end else begin
          req = 1'b1;
          if (memAck) begin
            complete = 1'b1;
          end else begin
            stall_int = 1'b1;
            state_d   = StWait;
          end
        end
      end
      StWait: begin
        if (timeout_hit) begin
          timed_out = 1'b1;
          state_d   = StIdle;
        end else begin
          req = 1'b1;
          if (memAck) begin
            complete = 1'b1;
            state_d  = StIdle;
          end else begin
            stall_int = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    wb_data_d = '0;
    aw_d      = '0;
    reg_wr_d  = 1'b0;
    instr_d   = '0;
    if (complete) begin
      // A store wins when both control bits are set, so read data is ignored.
      wb_data_d = (MemToRegIn && !MemWrIn) ? memRData : ALUIn;
      aw_d      = AwIn;
      reg_wr_d  = RegWrIn;
      instr_d   = instrIn;
    end else if (timed_out) begin
      aw_d    = AwIn;
      instr_d = instrIn;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      wb_data_q <= '0;
      aw_q      <= '0;
      reg_wr_q  <= 1'b0;
      instr_q   <= '0;
    end else begin
      state_q   <= state_d;
      wb_data_q <= wb_data_d;
      aw_q      <= aw_d;
      reg_wr_q  <= reg_wr_d;
      instr_q   <= instr_d;
    end
  end

  assign WbDataOut = wb_data_q;
  assign AwOut     = aw_q;
  assign RegWrOut  = reg_wr_q;
  assign instrOut  = instr_q;

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- Memory-access stage of the five-stage MIPS pipeline. It consumes the EX/MEM register bundle: ALU result, store data, write address, control bits and instruction.
- Drives a request/acknowledge data-memory port and stalls upstream stages while an access is outstanding.
- Registers the MEM/WB bundle that feeds register-file write-back.

Parameters:
- TIMEOUT, 16, cycles a request may wait for memAck before abort (used only with the optional feature).

Ports:
- clk  in  1  pipeline clock, rising edge
- reset  in  1  asynchronous, active-high
- ALUIn  in  32  EX/MEM ALU result: memory byte address or write-back value
- DbIn  in  32  EX/MEM store data
- AwIn  in  5  destination register
- RegWrIn  in  1  register write enable
- MemWrIn  in  1  store
- MemToRegIn  in  1  load
- instrIn  in  32  instruction word
- memAddr  out  32  data memory address
- memWData  out  32  data memory write data
- memWr  out  1  1 = write, 0 = read; valid only with memReq
- memReq  out  1  access request
- memAck  in  1  access complete; read data valid this cycle
- memRData  in  32  read data
- stall  out  1  hold PC, IF/ID, ID/EX and EX/MEM registers
- WbDataOut  out  32  MEM/WB write-back data
- AwOut  out  5  MEM/WB destination register
- RegWrOut  out  1  MEM/WB register write enable
- instrOut  out  32  MEM/WB instruction
- memErr  out  1  sticky access-timeout flag

Behaviour:
- Reset: asynchronous, takes effect immediately, including mid-access.
  - FSM goes to IDLE.
  - memReq, memWr, stall and memErr are 0.
  - WbDataOut, AwOut, RegWrOut and instrOut are 0.
- Memory op: memOp = MemWrIn | MemToRegIn.
- Combinational memory port: memAddr = ALUIn, memWData = DbIn, memWr = MemWrIn. These are driven regardless of state and are meaningful only while memReq = 1.
- IDLE, memOp = 0: stall = 0, memReq = 0. On the next edge the MEM/WB registers load WbData = ALUIn, AwIn, RegWrIn, instrIn. Latency is one cycle.
- IDLE, memOp = 1:
  - memReq = 1 in the same cycle.
  - If memAck = 1 in that cycle (zero-wait): stall = 0, the access completes, and the MEM/WB registers load on the edge.
  - Otherwise stall = 1, next state is WAIT, and the MEM/WB registers load a bubble: RegWr = 0, instr = 0, WbData = 0, Aw = 0.
- WAIT:
  - memReq = 1 and stall = 1 until memAck.
  - In the memAck cycle: stall = 0, the MEM/WB registers load the completed op, next state is IDLE.
  - Every non-ack cycle loads a bubble.
- Completed op write-back value:
  - Load: WbData = memRData.
  - Store: WbData = ALUIn; RegWrOut = RegWrIn as decoded.
- MemWrIn and MemToRegIn both set: treated as a store and memRData is ignored.
- Upstream contract: while stall = 1, all *In signals are held stable by the stalled EX/MEM register.
- memAck while memReq = 0 is ignored.
- Exactly one memory transaction per memOp instruction; back-to-back memory ops each issue a fresh request.

Optional Feature:
- Macro name: MEM_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to WAIT and increments each WAIT cycle.
  - If TIMEOUT WAIT cycles elapse without memAck: memReq drops, memErr sets (sticky until reset), the FSM returns to IDLE, and stall = 0 in that cycle.
  - On that edge the MEM/WB registers load the op with RegWr = 0, WbData = 0 and instr = instrIn.
- Undefined: no counter; WAIT persists until memAck; memErr is tied to 0.

Test Plan:
- Reset asserted mid-WAIT with memReq = 1 -> memReq, stall and all MEM/WB outputs 0 immediately, without waiting for a clock edge; after release the FSM is in IDLE.
- ALU op with ALUIn = 0x0000_0042, AwIn = 5, RegWrIn = 1 -> one edge later WbDataOut = 0x42, AwOut = 5, RegWrOut = 1; stall stays 0.
- Load, ALUIn = 0x100, memAck after 3 cycles with memRData = 0xDEADBEEF:
  - stall = 1 for 3 cycles, with bubbles (RegWrOut = 0) in MEM/WB.
  - Then WbDataOut = 0xDEADBEEF, RegWrOut = 1.
  - memAddr = 0x100 and memWr = 0 throughout.
- Store, ALUIn = 0x200, DbIn = 0x1234, memAck in the same cycle -> memReq = 1, memWr = 1, memWData = 0x1234; stall never asserts; one transaction.
- Two back-to-back loads with zero-wait ack -> two memReq cycles, two distinct MEM/WB results, no bubble.
- With MEM_TIMEOUT_EN and TIMEOUT = 4: load with memAck held at 0 -> memErr = 1 after 4 WAIT cycles, stall = 0, RegWrOut = 0; memErr remains 1 until reset.
